csi_fuzzer_ctrl: RTL
====================

// Module: csi_fuzzer_ctrl
// PURPOSE
//  Per-packet scheduler for the CSI fuzzer tap coefficients in tx_intf. Holds a small table of
//  {gain, rot90} tap pairs and loads one entry at each TX packet start. Keeps the coefficients
//  frozen for the whole packet and returns them to zero after a short drain. Can step through the
//  table across packets and can fuzz only every (pkt_div+1)-th packet.
// PARAMETERS
//  CSI_FUZZER_WIDTH  6  signed tap gain width, matches fuzzer datapath
//  TBL_AW            3  table address width; depth = 2**TBL_AW entries
//  PKT_DIV_WIDTH     8  width of packet-divider config and counter
//  DRAIN_CYCLES      4  clk cycles the gains stay held after pkt_end (fuzzer history flush)
// PORTS
//  clk                  in   1        clock
//  rstn                 in   1        reset, synchronous, active-low
//  fuzz_en              in   1        master enable, sampled only at pkt_start
//  seq_en               in   1        1: advance table index per fuzzed packet; 0: always entry 0
//  tbl_len              in   TBL_AW+1 number of valid entries; 0 treated as 1
//  pkt_div              in   PKT_DIV_WIDTH  fuzz one packet, then skip pkt_div packets
//  cfg_wr_en            in   1        table write strobe
//  cfg_wr_addr          in   TBL_AW   table write address
//  cfg_wr_data          in   2W+2     {rot2, gain2[W-1:0], rot1, gain1[W-1:0]}, W=CSI_FUZZER_WIDTH
//  pkt_start            in   1        1-cycle pulse, first cycle of a TX packet
//  pkt_end              in   1        1-cycle pulse, last cycle of a TX packet
//  bb_gain1             out  W signed tap-1 gain to fuzzer
//  bb_gain1_rot90_flag  out  1        tap-1 rotate flag
//  bb_gain2             out  W signed tap-2 gain to fuzzer
//  bb_gain2_rot90_flag  out  1        tap-2 rotate flag
//  fuzz_active          out  1        high while gains are nonzero-eligible (ACTIVE or DRAIN of a fuzzed pkt)
//  cur_idx              out  TBL_AW   table index of the entry loaded for the current/next fuzzed pkt
//  fuzz_pkt_cnt         out  16       count of fuzzed packets, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, cur_idx=0, div_cnt=0, drain counter 0, state IDLE. Table is not cleared.
//  Table: reg array, written in the cycle after cfg_wr_en; write to the live entry does not
//    change outputs mid-packet. The new value is used at the next load.
//  States: IDLE -> ACTIVE on pkt_start; ACTIVE -> DRAIN on pkt_end; DRAIN -> IDLE after
//    DRAIN_CYCLES cycles (counter loads DRAIN_CYCLES-1, IDLE when 0).
//  On pkt_start (any state), the block decides fuzz = fuzz_en && (div_cnt==0):
//    div_cnt <= (div_cnt==pkt_div) ? 0 : div_cnt+1.
//    fuzz=1: outputs <= table[cur_idx] on the next edge (latency 1 cycle). fuzz_active=1.
//      fuzz_pkt_cnt++ (saturating). If seq_en, cur_idx <= (cur_idx>=eff_len-1) ? 0 : cur_idx+1,
//      with eff_len = max(tbl_len,1). If !seq_en, cur_idx <= 0.
//    fuzz=0: outputs <= 0, fuzz_active=0; the state still enters ACTIVE.
//  ACTIVE: outputs frozen; fuzz_en/seq_en/pkt_div/table changes do not affect them.
//  DRAIN: outputs held. On leaving DRAIN, outputs and fuzz_active go 0 in the same cycle
//    the state becomes IDLE.
//  pkt_start in ACTIVE (missing pkt_end): treated as end+start; new entry loads directly, no drain.
//  pkt_start in DRAIN: abort drain, load as above.
//  pkt_start and pkt_end in the same cycle: pkt_start wins; pkt_end is ignored.
//  pkt_end in IDLE or DRAIN: ignored.
//  cur_idx >= eff_len (tbl_len reduced): next advance wraps to 0. The load itself uses cur_idx as is.
//  rstn low mid-packet: outputs 0 on the next edge, fuzzer sees unfuzzed IQ.
// TESTING
//  1 Reset, table[0]={0,5,1,-3}, fuzz_en=1,seq_en=0,pkt_div=0, start/end -> gains -3/rot1,5/rot0 at start+1; zero DRAIN_CYCLES after end.
//  2 tbl_len=3, seq_en=1, 5 packets -> entries loaded 0,1,2,0,1; fuzz_pkt_cnt=5.
//  3 pkt_div=2, 7 packets -> fuzzed packets 1,4,7 only; others output 0 with fuzz_active=0.
//  4 Mid-packet: write live entry, drop fuzz_en -> outputs unchanged until end+drain; next packet has zero gains.
//  5 pkt_start during DRAIN cycle 2 and pkt_start without pkt_end -> next entry at +1 cycle, no zero gap.
//  6 rstn low for 1 cycle mid-packet -> all outputs 0 next cycle, cur_idx=0, counters cleared.

Source files
------------

// File: rtl/csi_fuzzer_ctrl_if.sv
// Control/status bundle between the TX packet logic and the CSI fuzzer
// coefficient scheduler. The master drives the packet strobes, the
// configuration and the table writes. The slave (csi_fuzzer_ctrl) returns the
// tap coefficients and its status.
interface csi_fuzzer_ctrl_if #(
    parameter int W             = 6,
    parameter int TBL_AW        = 3,
    parameter int PKT_DIV_WIDTH = 8
);
    logic                       fuzz_en;
    logic                       seq_en;
    logic [TBL_AW:0]            tbl_len;
    logic [PKT_DIV_WIDTH-1:0]   pkt_div;
    logic                       cfg_wr_en;
    logic [TBL_AW-1:0]          cfg_wr_addr;
    logic [2*W+1:0]             cfg_wr_data;
    logic                       pkt_start;
    logic                       pkt_end;
    logic signed [W-1:0]        bb_gain1;
    logic                       bb_gain1_rot90_flag;
    logic signed [W-1:0]        bb_gain2;
    logic                       bb_gain2_rot90_flag;
    logic                       fuzz_active;
    logic [TBL_AW-1:0]          cur_idx;
    logic [15:0]                fuzz_pkt_cnt;

    modport master (
        output fuzz_en, seq_en, tbl_len, pkt_div,
        output cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        output pkt_start, pkt_end,
        input  bb_gain1, bb_gain1_rot90_flag, bb_gain2, bb_gain2_rot90_flag,
        input  fuzz_active, cur_idx, fuzz_pkt_cnt
    );

    modport slave (
        input  fuzz_en, seq_en, tbl_len, pkt_div,
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_data,
        input  pkt_start, pkt_end,
        output bb_gain1, bb_gain1_rot90_flag, bb_gain2, bb_gain2_rot90_flag,
        output fuzz_active, cur_idx, fuzz_pkt_cnt
    );
endinterface

// File: rtl/csi_fuzzer_ctrl.sv
// Per-packet scheduler for the CSI fuzzer tap coefficients. A small table of
// {gain, rot90} tap pairs is loaded one entry per fuzzed TX packet. The
// coefficients stay frozen for the whole packet, are held for a short drain
// after the packet ends, and then return to zero.
module csi_fuzzer_ctrl #(
    parameter int CSI_FUZZER_WIDTH = 6,
    parameter int TBL_AW           = 3,
    parameter int PKT_DIV_WIDTH    = 8,
    parameter int DRAIN_CYCLES     = 4
) (
    input  logic             clk,
    input  logic             rstn,
    csi_fuzzer_ctrl_if.slave bus
);
    localparam int W     = CSI_FUZZER_WIDTH;
    localparam int DEPTH = 2 ** TBL_AW;
    localparam int DW    = 2 * W + 2;
    localparam int DCW   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DRAIN
    } state_t;

    logic [DW-1:0]            tbl [DEPTH];
    state_t                   state;
    logic [DCW-1:0]           drain_cnt;
    logic [PKT_DIV_WIDTH-1:0] div_cnt;
    logic [TBL_AW-1:0]        idx;
    logic [15:0]              pkt_cnt;
    logic signed [W-1:0]      gain1;
    logic signed [W-1:0]      gain2;
    logic                     rot1;
    logic                     rot2;
    logic                     active;

    logic [DW-1:0]            entry;
    logic                     fuzz_now;
    logic [TBL_AW:0]          last_idx;
    logic                     idx_at_end;

    // The live entry is read combinationally; it only reaches the outputs at
    // a packet start, so a table write mid-packet cannot disturb the taps.
    assign entry      = tbl[idx];
    assign fuzz_now   = bus.fuzz_en && (div_cnt == '0);
    assign last_idx   = (bus.tbl_len == '0) ? '0 : bus.tbl_len - 1'b1;
    assign idx_at_end = ({1'b0, idx} >= last_idx);

    // Coefficient table; deliberately not reset so the configuration survives a
    // reset of the scheduler.
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en) begin
            tbl[bus.cfg_wr_addr] <= bus.cfg_wr_data;
        end
    end

    // Packet state machine with registered tap outputs and bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            div_cnt   <= '0;
            idx       <= '0;
            pkt_cnt   <= '0;
            gain1     <= '0;
            gain2     <= '0;
            rot1      <= 1'b0;
            rot2      <= 1'b0;
            active    <= 1'b0;
        end else if (bus.pkt_start) begin
            state     <= ST_ACTIVE;
            drain_cnt <= '0;
            div_cnt   <= (div_cnt == bus.pkt_div) ? '0 : div_cnt + 1'b1;
            if (fuzz_now) begin
                gain1  <= entry[W-1:0];
                rot1   <= entry[W];
                gain2  <= entry[2*W:W+1];
                rot2   <= entry[2*W+1];
                active <= 1'b1;
                if (pkt_cnt != 16'hFFFF) begin
                    pkt_cnt <= pkt_cnt + 16'd1;
                end
                if (bus.seq_en && !idx_at_end) begin
                    idx <= idx + 1'b1;
                end else begin
                    idx <= '0;
                end
            end else begin
                gain1  <= '0;
                rot1   <= 1'b0;
                gain2  <= '0;
                rot2   <= 1'b0;
                active <= 1'b0;
            end
        end else begin
            case (state)
                ST_ACTIVE: begin
                    if (bus.pkt_end) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DCW'(DRAIN_CYCLES - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= ST_IDLE;
                        gain1  <= '0;
                        rot1   <= 1'b0;
                        gain2  <= '0;
                        rot2   <= 1'b0;
                        active <= 1'b0;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.bb_gain1            = gain1;
    assign bus.bb_gain1_rot90_flag = rot1;
    assign bus.bb_gain2            = gain2;
    assign bus.bb_gain2_rot90_flag = rot2;
    assign bus.fuzz_active         = active;
    assign bus.cur_idx             = idx;
    assign bus.fuzz_pkt_cnt        = pkt_cnt;
endmodule
